bip_control: RTL and testbench



---
 rtl/bip_pkg.sv | 35 +++
 rtl/bip_decoder.sv | 73 +++++++
 rtl/bip_control.sv | 109 ++++++++++
 tb/tb_bip_control.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bip_pkg
// Purpose  : Shared encodings for the BIP control unit: opcodes, ACC source
//            selects, ALU B source selects, ALU operations and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package bip_pkg;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SELA_DM  = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  localparam logic SELB_IMM = 1'b0;
  localparam logic SELB_DM  = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage : bip_pkg
`default_nettype wire

// File: rtl/bip_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bip_decoder
// Purpose  : Purely combinational opcode decoder. Produces raw (ungated)
//            datapath controls; the caller qualifies strobes with exec.
// Ports    : i_opc        opcode field of the instruction
//            o_sel_a      ACC source select
//            o_sel_b      ALU B source select
//            o_op         ALU operation
//            o_wr_acc     ACC write request
//            o_wr_ram     data-memory write request
//            o_rd_ram     data-memory read request
//            o_is_hlt     opcode is HLT
//            o_is_illegal opcode is undefined
// Revision : 1.0 - initial release
// ============================================================================
module bip_decoder
  import bip_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] i_opc,
  output logic [1:0]       o_sel_a,
  output logic             o_sel_b,
  output logic             o_op,
  output logic             o_wr_acc,
  output logic             o_wr_ram,
  output logic             o_rd_ram,
  output logic             o_is_hlt,
  output logic             o_is_illegal
);

  always_comb begin
    o_sel_a      = SELA_DM;
    o_sel_b      = SELB_IMM;
    o_op         = ALU_ADD;
    o_wr_acc     = 1'b0;
    o_wr_ram     = 1'b0;
    o_rd_ram     = 1'b0;
    o_is_hlt     = 1'b0;
    o_is_illegal = 1'b0;
    case (i_opc)
      OPC_HLT: o_is_hlt = 1'b1;
      OPC_STO: o_wr_ram = 1'b1;
      OPC_LD: begin
        o_rd_ram = 1'b1;
        o_sel_a  = SELA_DM;
        o_wr_acc = 1'b1;
      end
      OPC_LDI: begin
        o_sel_a  = SELA_IMM;
        o_wr_acc = 1'b1;
      end
      OPC_ADD, OPC_SUB: begin
        o_rd_ram = 1'b1;
        o_sel_b  = SELB_DM;
        o_op     = (i_opc == OPC_SUB) ? ALU_SUB : ALU_ADD;
        o_sel_a  = SELA_ALU;
        o_wr_acc = 1'b1;
      end
      OPC_ADDI, OPC_SUBI: begin
        o_sel_b  = SELB_IMM;
        o_op     = (i_opc == OPC_SUBI) ? ALU_SUB : ALU_ADD;
        o_sel_a  = SELA_ALU;
        o_wr_acc = 1'b1;
      end
      // Undefined opcodes behave as NOP but are flagged.
      default: o_is_illegal = 1'b1;
    endcase
  end

endmodule : bip_decoder
`default_nettype wire

// File: rtl/bip_control.sv
`default_nettype none
// ============================================================================
// Module   : bip_control
// Purpose  : Control unit of the BIP accumulator processor. Owns the PC,
//            fetches from asynchronous program memory, decodes each
//            instruction into datapath controls and runs one instruction per
//            clock until HLT, with an optional single-step debug mode.
// Ports    : CLK, RESET          clock, synchronous active-high reset
//            INSTR_IN            program-memory data at PC_OUT
//            STEP_MODE/PULSE     step-mode enable / per-cycle execute enable
//            PC_OUT              program-memory address
//            OPERAND_OUT         instruction operand field
//            SEL_A, SEL_B, OP    datapath selects (not gated by exec)
//            WR_ACC/WR_RAM/RD_RAM strobes (gated by exec)
//            HALTED, ILLEGAL     status; ILLEGAL is sticky until reset
//            RETIRED             saturating executed-instruction count
// Revision : 1.0 - initial release
// ============================================================================
module bip_control
  import bip_pkg::*;
#(
  parameter int PC_W  = 11,
  parameter int OPC_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [15:0]      INSTR_IN,
  input  logic             STEP_MODE,
  input  logic             STEP_PULSE,
  output logic [PC_W-1:0]  PC_OUT,
  output logic [10:0]      OPERAND_OUT,
  output logic [1:0]       SEL_A,
  output logic             SEL_B,
  output logic             WR_ACC,
  output logic             OP,
  output logic             WR_RAM,
  output logic             RD_RAM,
  output logic             HALTED,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] RETIRED
);

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [CNT_W-1:0]  r_retired;
  logic              r_illegal;

  logic [OPC_W-1:0]  w_opc;
  logic              w_exec;
  logic              w_wr_acc;
  logic              w_wr_ram;
  logic              w_rd_ram;
  logic              w_is_hlt;
  logic              w_is_illegal;

  assign w_opc = INSTR_IN[15 -: OPC_W];

  bip_decoder #(
    .OPC_W (OPC_W)
  ) u_decoder (
    .i_opc        (w_opc),
    .o_sel_a      (SEL_A),
    .o_sel_b      (SEL_B),
    .o_op         (OP),
    .o_wr_acc     (w_wr_acc),
    .o_wr_ram     (w_wr_ram),
    .o_rd_ram     (w_rd_ram),
    .o_is_hlt     (w_is_hlt),
    .o_is_illegal (w_is_illegal)
  );

  // RESET is folded in so that a reset cycle aborts the instruction
  // combinationally, not just from the next edge on.
  assign w_exec = (r_state == ST_RUN) && (!STEP_MODE || STEP_PULSE) && !RESET;

  assign WR_ACC      = w_wr_acc & w_exec;
  assign WR_RAM      = w_wr_ram & w_exec;
  assign RD_RAM      = w_rd_ram & w_exec;
  assign OPERAND_OUT = INSTR_IN[10:0];
  assign PC_OUT      = r_pc;
  assign HALTED      = (r_state == ST_HALT);
  assign ILLEGAL     = r_illegal;
  assign RETIRED     = r_retired;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_RUN;
      r_pc      <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else if (w_exec) begin
      if (w_is_hlt) begin
        r_state <= ST_HALT;
      end else begin
        // PC wraps naturally at 2^PC_W.
        r_pc <= r_pc + 1'b1;
        if (r_retired != '1) begin
          r_retired <= r_retired + 1'b1;
        end
        if (w_is_illegal) begin
          r_illegal <= 1'b1;
        end
      end
    end
  end

endmodule : bip_control
`default_nettype wire

// File: tb/tb_bip_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_bip_control
// Purpose  : Self-checking bench for bip_control against an architectural
//            model of the BIP control unit (PC, halt, sticky illegal flag,
//            retired count, per-opcode control table).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bip_control;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] INSTR_IN;
  logic        STEP_MODE;
  logic        STEP_PULSE;
  logic [10:0] PC_OUT;
  logic [10:0] OPERAND_OUT;
  logic [1:0]  SEL_A;
  logic        SEL_B;
  logic        WR_ACC;
  logic        OP;
  logic        WR_RAM;
  logic        RD_RAM;
  logic        HALTED;
  logic        ILLEGAL;
  logic [31:0] RETIRED;

  always #5 CLK = ~CLK;

  bip_control #(
    .PC_W  (11),
    .OPC_W (5),
    .CNT_W (32)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTR_IN    (INSTR_IN),
    .STEP_MODE   (STEP_MODE),
    .STEP_PULSE  (STEP_PULSE),
    .PC_OUT      (PC_OUT),
    .OPERAND_OUT (OPERAND_OUT),
    .SEL_A       (SEL_A),
    .SEL_B       (SEL_B),
    .WR_ACC      (WR_ACC),
    .OP          (OP),
    .WR_RAM      (WR_RAM),
    .RD_RAM      (RD_RAM),
    .HALTED      (HALTED),
    .ILLEGAL     (ILLEGAL),
    .RETIRED     (RETIRED)
  );

  int total = 0;
  int bad   = 0;

  // Architectural model state
  int unsigned m_pc;
  longint      m_ret;
  bit          m_halt;
  bit          m_ill;

  logic [17:0] e_str;
  logic [17:0] obs_str;
  logic [44:0] obs_st;
  logic [44:0] exp_st;

  assign obs_str = {OPERAND_OUT, SEL_A, SEL_B, OP, WR_ACC, WR_RAM, RD_RAM};
  assign obs_st  = {PC_OUT, RETIRED, HALTED, ILLEGAL};
  assign exp_st  = {m_pc[10:0], m_ret[31:0], m_halt, m_ill};

  localparam logic [15:0] I_HLT  = 16'h0000;
  localparam logic [15:0] I_STO  = 16'h0800;
  localparam logic [15:0] I_LD   = 16'h1000;
  localparam logic [15:0] I_LDI  = 16'h1800;
  localparam logic [15:0] I_ADD  = 16'h2000;
  localparam logic [15:0] I_ADDI = 16'h2800;
  localparam logic [15:0] I_SUB  = 16'h3000;

  // Expected controls from the opcode table; strobes only when executing.
  function automatic logic [17:0] exp_ctrl(logic [15:0] ins, logic sm, logic sp, logic rst);
    bit ex;
    int opc;
    logic [1:0] sa;
    logic sb, op, wa, wr, rd;
    ex  = !m_halt && (!sm || sp) && !rst;
    opc = int'(ins[15:11]);
    sa = 2'b00; sb = 1'b0; op = 1'b0; wa = 1'b0; wr = 1'b0; rd = 1'b0;
    case (opc)
      1: wr = 1'b1;
      2: begin rd = 1'b1; wa = 1'b1; end
      3: begin sa = 2'b01; wa = 1'b1; end
      4, 6: begin rd = 1'b1; sb = 1'b1; sa = 2'b10; wa = 1'b1; op = (opc == 6); end
      5, 7: begin sa = 2'b10; wa = 1'b1; op = (opc == 7); end
      default: ;
    endcase
    return {ins[10:0], sa, sb, op, wa & ex, wr & ex, rd & ex};
  endfunction

  task automatic apply(input logic [15:0] ins, input logic sm, input logic sp, input logic rst);
    INSTR_IN   = ins;
    STEP_MODE  = sm;
    STEP_PULSE = sp;
    RESET      = rst;
    e_str      = exp_ctrl(ins, sm, sp, rst);
    #2;
  endtask

  // Advance the model with the inputs currently applied, then clock the DUT.
  task automatic advance();
    bit ex;
    ex = !m_halt && (!STEP_MODE || STEP_PULSE) && !RESET;
    if (RESET) begin
      m_pc = 0; m_ret = 0; m_halt = 0; m_ill = 0;
    end else if (ex) begin
      if (INSTR_IN[15:11] == 5'd0) begin
        m_halt = 1;
      end else begin
        m_pc = (m_pc + 1) % 2048;
        if (m_ret < 64'hFFFF_FFFF) m_ret = m_ret + 1;
        if (INSTR_IN[15:11] > 5'd7) m_ill = 1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    apply(16'h0000, 1'b0, 1'b0, 1'b1);
    advance();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply(16'($urandom), 1'b0, 1'b1, 1'b1);
      total++;
      if (obs_str !== e_str) begin bad++; $display("FAIL reset_ctrl: got %h want %h", obs_str, e_str); end
      advance();
      total++;
      if (obs_st !== exp_st) begin bad++; $display("FAIL reset_state: got %h want %h", obs_st, exp_st); end
    end
  endtask

  task automatic test_sequence();
    logic [15:0] prog [4];
    prog[0] = I_LDI | 16'd5;
    prog[1] = I_ADDI | 16'd3;
    prog[2] = I_STO | 16'h010;
    prog[3] = I_HLT;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(prog[i], 1'b0, 1'b0, 1'b0);
      total++;
      if (obs_str !== e_str) begin bad++; $display("FAIL seq_ctrl[%0d]: got %h want %h", i, obs_str, e_str); end
      advance();
      total++;
      if (obs_st !== exp_st) begin bad++; $display("FAIL seq_state[%0d]: got %h want %h", i, obs_st, exp_st); end
    end
    total++;
    if ({PC_OUT, RETIRED, HALTED} !== {11'd3, 32'd3, 1'b1}) begin
      bad++;
      $display("FAIL seq_end: got pc=%h ret=%0d halted=%b want pc=003 ret=3 halted=1", PC_OUT, RETIRED, HALTED);
    end
  endtask

  task automatic test_mem_operand();
    do_reset();
    apply(I_LD | 16'h004, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_str !== e_str) begin bad++; $display("FAIL ld_ctrl: got %h want %h", obs_str, e_str); end
    advance();
    apply(I_SUB | 16'h005, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_str[6:0] !== 7'b10_1_1_1_0_1) begin bad++; $display("FAIL sub_ctrl: got %b want 1011101", obs_str[6:0]); end
    advance();
    total++;
    if (obs_st !== exp_st) begin bad++; $display("FAIL mem_state: got %h want %h", obs_st, exp_st); end
  endtask

  task automatic test_step();
    logic [10:0] pc0;
    logic [15:0] ins;
    do_reset();
    pc0 = PC_OUT;
    for (int i = 0; i < 5; i++) begin
      ins = {5'($urandom_range(1, 7)), 11'($urandom)};
      apply(ins, 1'b1, 1'b0, 1'b0);
      total++;
      if (obs_str !== e_str) begin bad++; $display("FAIL step_idle_ctrl[%0d]: got %h want %h", i, obs_str, e_str); end
      advance();
      total++;
      if (obs_st !== exp_st) begin bad++; $display("FAIL step_idle_state[%0d]: got %h want %h", i, obs_st, exp_st); end
    end
    apply(I_LDI | 16'd9, 1'b1, 1'b1, 1'b0);
    total++;
    if (obs_str !== e_str) begin bad++; $display("FAIL step_pulse_ctrl: got %h want %h", obs_str, e_str); end
    advance();
    total++;
    if (PC_OUT !== pc0 + 11'd1) begin bad++; $display("FAIL step_pulse_pc: got %h want %h", PC_OUT, pc0 + 11'd1); end
    // Back-to-back: pulse held high for 3 cycles executes 3 instructions.
    for (int i = 0; i < 3; i++) begin
      apply(I_ADDI | 16'(i), 1'b1, 1'b1, 1'b0);
      advance();
    end
    total++;
    if (obs_st !== exp_st || PC_OUT !== pc0 + 11'd4) begin
      bad++;
      $display("FAIL step_held: got %h want %h", obs_st, exp_st);
    end
  endtask

  task automatic test_illegal_wrap();
    do_reset();
    for (int i = 0; i < 2047; i++) begin
      apply(I_LDI, 1'b0, 1'b0, 1'b0);
      advance();
    end
    total++;
    if (PC_OUT !== 11'h7FF) begin bad++; $display("FAIL wrap_pre_pc: got %h want 7ff", PC_OUT); end
    apply(16'hF800 | 16'($urandom_range(0, 2047)), 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_str !== e_str) begin bad++; $display("FAIL illegal_ctrl: got %h want %h", obs_str, e_str); end
    advance();
    total++;
    if (obs_st !== exp_st || PC_OUT !== 11'h000 || ILLEGAL !== 1'b1) begin
      bad++;
      $display("FAIL illegal_state: got %h want %h", obs_st, exp_st);
    end
    for (int i = 0; i < 3; i++) begin
      apply(I_ADD | 16'(i), 1'b0, 1'b0, 1'b0);
      advance();
    end
    total++;
    if (obs_st !== exp_st || ILLEGAL !== 1'b1) begin bad++; $display("FAIL illegal_sticky: got %h want %h", obs_st, exp_st); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(I_LDI | 16'(i), 1'b0, 1'b0, 1'b0);
      advance();
    end
    total++;
    if (PC_OUT !== 11'd7) begin bad++; $display("FAIL rmid_pc: got %h want 007", PC_OUT); end
    apply(I_ADDI | 16'd1, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs_str !== e_str || WR_ACC !== 1'b0) begin bad++; $display("FAIL rmid_ctrl: got %h want %h", obs_str, e_str); end
    advance();
    total++;
    if (obs_st !== exp_st) begin bad++; $display("FAIL rmid_state: got %h want %h", obs_st, exp_st); end
  endtask

  task automatic test_halt();
    logic [44:0] snap;
    do_reset();
    apply(I_LDI | 16'd1, 1'b0, 1'b0, 1'b0);
    advance();
    apply(I_HLT, 1'b0, 1'b0, 1'b0);
    advance();
    snap = exp_st;
    for (int i = 0; i < 10; i++) begin
      apply(16'($urandom), 1'($urandom), 1'b1, 1'b0);
      total++;
      if (obs_str[2:0] !== 3'b000 || obs_str !== e_str) begin
        bad++;
        $display("FAIL halt_ctrl[%0d]: got %h want %h", i, obs_str, e_str);
      end
      advance();
      total++;
      if (obs_st !== snap) begin bad++; $display("FAIL halt_state[%0d]: got %h want %h", i, obs_st, snap); end
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic        rst;
    int          r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)       ins = {5'd0, 11'($urandom)};
      else if (r < 16)  ins = {5'($urandom_range(1, 7)), 11'($urandom)};
      else              ins = {5'($urandom_range(8, 31)), 11'($urandom)};
      rst = ($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 3) == 0);
      apply(ins, 1'($urandom), 1'($urandom), rst);
      total++;
      if (obs_str !== e_str) begin bad++; $display("FAIL rand_ctrl[%0d]: got %h want %h", i, obs_str, e_str); end
      advance();
      total++;
      if (obs_st !== exp_st) begin bad++; $display("FAIL rand_state[%0d]: got %h want %h", i, obs_st, exp_st); end
    end
  endtask

  initial begin
    RESET = 1'b1; INSTR_IN = '0; STEP_MODE = 1'b0; STEP_PULSE = 1'b0;
    m_pc = 0; m_ret = 0; m_halt = 0; m_ill = 0;
    e_str = '0;
    @(posedge CLK);
    #1;
    test_reset();
    test_sequence();
    test_mem_operand();
    test_step();
    test_illegal_wrap();
    test_reset_mid();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bip_control
`default_nettype wire
